// File: rtl/pistorm_txn_queue.sv
// Transaction queue between the Pi register port and the 68K bus sequencer.
// Staged address/data/size/direction are pushed on ADDR_HI writes and issued in order over req/ack.
module pistorm_txn_queue #(
    parameter int DEPTH = 4
) (
    input  logic        M68K_CLK,
    input  logic        RESET,
    input  logic        REG_WE,
    input  logic [1:0]  REG_A,
    input  logic [15:0] REG_D,
    input  logic        BUS_ACK,
    input  logic [15:0] BUS_RDATA,
    input  logic        BUS_ABORT,
    output logic        BUS_REQ,
    output logic [22:0] BUS_ADDR,
    output logic [15:0] BUS_WDATA,
    output logic        BUS_RW,
    output logic        BUS_SZ,
    output logic        BUS_A0,
    output logic [15:0] RD_DATA,
    output logic        TXN_IN_PROGRESS,
    output logic        QUEUE_FULL,
    output logic        OVERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] wdata;
        logic        rw;
        logic        sz;
        logic        a0;
    } entry_t;

    entry_t      r_mem [DEPTH];
    logic [15:0] r_stage_d;
    logic [15:1] r_stage_a_lo;
    logic [7:0]  r_stage_a_hi;
    logic        r_stage_a0;
    logic        r_stage_sz;
    logic        r_stage_rw;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0] r_rd_data;
    logic        r_overflow;
    logic        r_gap;
    state_t      r_state;
    state_t      w_state_next;

    logic   w_push, w_pop, w_accept, w_not_empty, w_full;
    entry_t w_entry, w_head;

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == C_DEPTH);
    assign w_push      = REG_WE && (REG_A == 2'd2);
    assign w_pop       = BUS_ACK && (r_state == ST_REQ) && w_not_empty && !BUS_ABORT;
    // A pop in the same cycle frees a slot, so a full queue still accepts the push.
    assign w_accept    = w_push && (!w_full || w_pop) && !BUS_ABORT;
    assign w_entry     = '{addr: {REG_D[7:0], r_stage_a_lo}, wdata: r_stage_d,
                           rw: REG_D[9], sz: REG_D[8], a0: r_stage_a0};
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) begin
            r_stage_d    <= '0;
            r_stage_a_lo <= '0;
            r_stage_a_hi <= '0;
            r_stage_a0   <= 1'b0;
            r_stage_sz   <= 1'b0;
            r_stage_rw   <= 1'b0;
        end else if (REG_WE) begin
            case (REG_A)
                2'd0: r_stage_d <= REG_D;
                2'd1: begin
                    r_stage_a_lo <= REG_D[15:1];
                    r_stage_a0   <= REG_D[0];
                end
                2'd2: begin
                    r_stage_a_hi <= REG_D[7:0];
                    r_stage_sz   <= REG_D[8];
                    r_stage_rw   <= REG_D[9];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_gap     <= 1'b0;
        end else if (BUS_ABORT) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_gap    <= 1'b0;
        end else begin
            r_gap <= w_pop;
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_head.rw) r_rd_data <= BUS_RDATA;
            end
            if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop && !BUS_ABORT)
            r_overflow <= 1'b1;
    end

    always_ff @(posedge M68K_CLK or posedge RESET) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // The ack gap holds the request low one full cycle so the sequencer re-samples the head.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_not_empty && !r_gap) w_state_next = ST_REQ;
            ST_REQ:  if (w_pop) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (BUS_ABORT) w_state_next = ST_IDLE;
    end

    assign BUS_REQ         = (r_state == ST_REQ);
    assign BUS_ADDR        = w_not_empty ? w_head.addr  : '0;
    assign BUS_WDATA       = w_not_empty ? w_head.wdata : '0;
    assign BUS_RW          = w_not_empty ? w_head.rw    : 1'b1;
    assign BUS_SZ          = w_not_empty ? w_head.sz    : 1'b0;
    assign BUS_A0          = w_not_empty ? w_head.a0    : 1'b0;
    assign RD_DATA         = r_rd_data;
    assign TXN_IN_PROGRESS = w_not_empty;
    assign QUEUE_FULL      = w_full;
    assign OVERFLOW        = r_overflow;
endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Bench for pistorm_txn_queue: vector table plus scoreboarded multi-cycle sequences.
module tb_pistorm_txn_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_we = 1'b0;
    logic [1:0]  reg_a = '0;
    logic [15:0] reg_d = '0;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = '0;
    logic        bus_abort = 1'b0;
    logic        bus_req, bus_rw, bus_sz, bus_a0, txn, qfull, ovf;
    logic [22:0] bus_addr;
    logic [15:0] bus_wdata, rd_data;

    pistorm_txn_queue #(.DEPTH(DEPTH)) dut (
        .M68K_CLK(clk), .RESET(rst), .REG_WE(reg_we), .REG_A(reg_a), .REG_D(reg_d),
        .BUS_ACK(bus_ack), .BUS_RDATA(bus_rdata), .BUS_ABORT(bus_abort),
        .BUS_REQ(bus_req), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata), .BUS_RW(bus_rw),
        .BUS_SZ(bus_sz), .BUS_A0(bus_a0), .RD_DATA(rd_data), .TXN_IN_PROGRESS(txn),
        .QUEUE_FULL(qfull), .OVERFLOW(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] wdata;
        logic        rw;
        logic        sz;
        logic        a0;
    } ent_t;

    typedef struct {
        logic [15:0] d, alo, ahi, rdata;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic        rw, sz, a0;
        logic [15:0] rd;
    } vec_t;

    ent_t        sb[$];
    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_d = '0, m_alo = '0, m_rd = '0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_we = 1'b1; reg_a = a; reg_d = d;
        tick();
        reg_we = 1'b0;
        if (a == 2'd0) m_d = d;
        if (a == 2'd1) m_alo = d;
    endtask

    function automatic ent_t mk_ent(input logic [15:0] ahi);
        ent_t e;
        e.addr = {ahi[7:0], m_alo[15:1]};
        e.wdata = m_d; e.rw = ahi[9]; e.sz = ahi[8]; e.a0 = m_alo[0];
        return e;
    endfunction

    task automatic push(input logic [15:0] ahi);
        ent_t e;
        e = mk_ent(ahi);
        wr(2'd2, ahi);
        if (sb.size() < DEPTH) sb.push_back(e);
        else m_ovf = 1'b1;
        $display("push addr=0x%06h wdata=0x%04h rw=%0d sz=%0d a0=%0d q=%0d", e.addr, e.wdata, e.rw, e.sz, e.a0, sb.size());
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && !bus_req; i++) tick();
        chk("req_wait", {31'd0, bus_req}, 32'd1);
    endtask

    task automatic chk_head(input string tag, input ent_t e);
        chk({tag, "_addr"},  {9'd0, bus_addr},   {9'd0, e.addr});
        chk({tag, "_wdata"}, {16'd0, bus_wdata}, {16'd0, e.wdata});
        chk({tag, "_rw"},    {31'd0, bus_rw},    {31'd0, e.rw});
        chk({tag, "_sz"},    {31'd0, bus_sz},    {31'd0, e.sz});
        chk({tag, "_a0"},    {31'd0, bus_a0},    {31'd0, e.a0});
    endtask

    task automatic ack(input logic [15:0] rdata);
        ent_t e;
        wait_req();
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk_head("head", e);
        bus_ack = 1'b1; bus_rdata = rdata;
        tick();
        bus_ack = 1'b0;
        if (e.rw) m_rd = rdata;
        $display("ack addr=0x%06h rw=%0d rdata=0x%04h rd=0x%04h q=%0d", e.addr, e.rw, rdata, rd_data, sb.size());
        chk("ack_rd", {16'd0, rd_data}, {16'd0, m_rd});
        chk("ack_req_low", {31'd0, bus_req}, 32'd0);
        chk("ack_txn", {31'd0, txn}, {31'd0, sb.size() != 0});
        tick();
        chk("gap_req_low", {31'd0, bus_req}, 32'd0);
        tick();
        chk("gap_req_after", {31'd0, bus_req}, {31'd0, sb.size() != 0});
    endtask

    initial begin
        vecs[0] = '{d:16'h1234, alo:16'h5678, ahi:16'h0200, rdata:16'hCAFE,
                    addr:23'h002B3C, wdata:16'h1234, rw:1'b1, sz:1'b0, a0:1'b0, rd:16'hCAFE};
        vecs[1] = '{d:16'h0000, alo:16'h0001, ahi:16'h0300, rdata:16'hBEEF,
                    addr:23'h000000, wdata:16'h0000, rw:1'b1, sz:1'b1, a0:1'b1, rd:16'hBEEF};
        vecs[2] = '{d:16'hA5A5, alo:16'hFFFE, ahi:16'h00FF, rdata:16'h1111,
                    addr:23'h7FFFFF, wdata:16'hA5A5, rw:1'b0, sz:1'b0, a0:1'b0, rd:16'hBEEF};
        vecs[3] = '{d:16'h0F0F, alo:16'h8001, ahi:16'h0112, rdata:16'h2222,
                    addr:23'h094000, wdata:16'h0F0F, rw:1'b0, sz:1'b1, a0:1'b1, rd:16'hBEEF};

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_req",  {31'd0, bus_req}, 32'd0);
        chk("rst_rw",   {31'd0, bus_rw},  32'd1);
        chk("rst_addr", {9'd0, bus_addr}, 32'd0);
        chk("rst_rd",   {16'd0, rd_data}, 32'd0);
        chk("rst_txn",  {31'd0, txn},     32'd0);
        chk("rst_full", {31'd0, qfull},   32'd0);
        chk("rst_ovf",  {31'd0, ovf},     32'd0);

        // Single transactions from the vector table.
        for (int i = 0; i < 4; i++) begin
            wr(2'd0, vecs[i].d);
            wr(2'd1, vecs[i].alo);
            push(vecs[i].ahi);
            chk("vec_txn", {31'd0, txn}, 32'd1);
            chk("vec_req_lat0", {31'd0, bus_req}, 32'd0);
            chk("vec_addr",  {9'd0, bus_addr},   {9'd0, vecs[i].addr});
            chk("vec_wdata", {16'd0, bus_wdata}, {16'd0, vecs[i].wdata});
            chk("vec_rw", {31'd0, bus_rw}, {31'd0, vecs[i].rw});
            chk("vec_sz", {31'd0, bus_sz}, {31'd0, vecs[i].sz});
            chk("vec_a0", {31'd0, bus_a0}, {31'd0, vecs[i].a0});
            tick();
            chk("vec_req_lat1", {31'd0, bus_req}, 32'd1);
            ack(vecs[i].rdata);
            chk("vec_rd", {16'd0, rd_data}, {16'd0, vecs[i].rd});
            chk("vec_empty_rw", {31'd0, bus_rw}, 32'd1);
        end

        // Fill past DEPTH with no acks, then drain in order.
        wr(2'd1, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 16'h1000 + 16'(i));
            push(16'h0040 + 16'(i));
            if (i == 2) chk("full_at3", {31'd0, qfull}, 32'd0);
            if (i == 3) chk("full_at4", {31'd0, qfull}, 32'd1);
            if (i == 3) chk("ovf_at4",  {31'd0, ovf},   32'd0);
        end
        chk("ovf_at5", {31'd0, ovf}, {31'd0, m_ovf});
        chk("full_still", {31'd0, qfull}, 32'd1);
        for (int i = 0; i < 4; i++) ack(16'h5500 + 16'(i));
        chk("drain_txn", {31'd0, txn}, 32'd0);

        // Push and ack in the same cycle with two entries queued.
        wr(2'd1, 16'h2002); wr(2'd0, 16'hAAAA); push(16'h0001);
        wr(2'd0, 16'hBBBB); push(16'h0202);
        wait_req();
        wr(2'd0, 16'hCCCC);
        begin
            ent_t e_head, e_new;
            e_head = sb.pop_front();
            chk_head("pa_before", e_head);
            e_new = mk_ent(16'h0103);
            reg_we = 1'b1; reg_a = 2'd2; reg_d = 16'h0103;
            bus_ack = 1'b1; bus_rdata = 16'h7777;
            tick();
            reg_we = 1'b0; bus_ack = 1'b0;
            sb.push_back(e_new);
            if (e_head.rw) m_rd = 16'h7777;
            $display("push+ack popped=0x%06h pushed=0x%06h q=%0d", e_head.addr, e_new.addr, sb.size());
            chk("pa_txn", {31'd0, txn}, 32'd1);
            chk("pa_full", {31'd0, qfull}, 32'd0);
            chk("pa_req", {31'd0, bus_req}, 32'd0);
            chk_head("pa_after", sb[0]);
        end
        ack(16'h3333);
        ack(16'h4444);
        chk("pa_drained", {31'd0, txn}, 32'd0);

        // Pointer wrap over repeated push/pop pairs.
        for (int i = 0; i < 9; i++) begin
            wr(2'd0, 16'h9000 + 16'(i));
            push(16'h0210 + 16'(i));
            ack(16'h6000 + 16'(i));
        end

        // Abort with three queued entries and a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            wr(2'd0, 16'h7000 + 16'(i));
            push(16'h0020 + 16'(i));
        end
        chk("abort_pre_txn", {31'd0, txn}, 32'd1);
        reg_we = 1'b1; reg_a = 2'd2; reg_d = 16'h0033; bus_abort = 1'b1;
        tick();
        reg_we = 1'b0; bus_abort = 1'b0;
        sb.delete();
        $display("abort q=%0d", sb.size());
        chk("abort_txn", {31'd0, txn}, 32'd0);
        chk("abort_req", {31'd0, bus_req}, 32'd0);
        chk("abort_full", {31'd0, qfull}, 32'd0);
        chk("abort_rd", {16'd0, rd_data}, {16'd0, m_rd});
        chk("abort_ovf", {31'd0, ovf}, {31'd0, m_ovf});
        tick(); tick();
        chk("abort_req_later", {31'd0, bus_req}, 32'd0);
        chk("abort_txn_later", {31'd0, txn}, 32'd0);
        wr(2'd0, 16'hD00D); push(16'h0244);
        ack(16'hF00D);

        // Asynchronous reset while requesting, then a stray ack.
        wr(2'd0, 16'hE0E0); push(16'h0201);
        wait_req();
        #1 rst = 1'b1;
        #1;
        chk("arst_req",  {31'd0, bus_req}, 32'd0);
        chk("arst_rd",   {16'd0, rd_data}, 32'd0);
        chk("arst_txn",  {31'd0, txn},     32'd0);
        chk("arst_ovf",  {31'd0, ovf},     32'd0);
        chk("arst_rw",   {31'd0, bus_rw},  32'd1);
        chk("arst_addr", {9'd0, bus_addr}, 32'd0);
        sb.delete(); m_d = '0; m_alo = '0; m_rd = '0; m_ovf = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 16'hDEAD;
        tick();
        bus_ack = 1'b0;
        $display("stray ack rd=0x%04h", rd_data);
        chk("stray_rd",  {16'd0, rd_data}, 32'd0);
        chk("stray_req", {31'd0, bus_req}, 32'd0);
        tick();
        chk("stray_req2", {31'd0, bus_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
